// File: rtl/mem_responder.sv
// Register-array memory slave answering a rd/wr strobe controller with a
// programmable read latency and registered ready/oe/ack/err handshakes.
module mem_responder #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_oe,
  output logic              ready,
  output logic              wr_ack,
  output logic              err
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic              oe_q, oe_d;
  logic              ready_q, ready_d;
  logic              wr_ack_q, wr_ack_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic              launch;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    oe_d       = oe_q;
    ready_d    = ready_q;
    wr_ack_d   = 1'b0;
    err_d      = 1'b0;
    wr_en      = 1'b0;
    launch     = 1'b0;

    if (rd && wr) begin
      state_d    = IDLE;
      data_out_d = '0;
      oe_d       = 1'b0;
      ready_d    = 1'b0;
      err_d      = 1'b1;
    end else if (wr) begin
      wr_en      = 1'b1;
      wr_ack_d   = 1'b1;
      state_d    = IDLE;
      data_out_d = '0;
      oe_d       = 1'b0;
      ready_d    = 1'b0;
    end else if (!rd) begin
      state_d    = IDLE;
      data_out_d = '0;
      oe_d       = 1'b0;
      ready_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: launch = 1'b1;
        WAIT: begin
          if (addr != addr_q)     launch  = 1'b1;
          else if (cnt_q == 2'd0) state_d = DRIVE;
          else                    cnt_d   = cnt_q - 2'd1;
        end
        DRIVE: begin
          // Data is captured once on the first DRIVE cycle and then held.
          if (addr != addr_q) begin
            launch = 1'b1;
          end else if (!ready_q) begin
            data_out_d = mem_q[addr_q];
            oe_d       = 1'b1;
            ready_d    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (launch) begin
      addr_d     = addr;
      data_out_d = '0;
      oe_d       = 1'b0;
      ready_d    = 1'b0;
      if (RD_LAT == 1) begin
        state_d = DRIVE;
      end else begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      addr_q     <= '0;
      data_out_q <= '0;
      oe_q       <= 1'b0;
      ready_q    <= 1'b0;
      wr_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      oe_q       <= oe_d;
      ready_q    <= ready_d;
      wr_ack_q   <= wr_ack_d;
      err_q      <= err_d;
    end
  end

  // Storage survives reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && rst_) mem_q[addr] <= data_in;
  end

  assign data_out = data_out_q;
  assign data_oe  = oe_q;
  assign ready    = ready_q;
  assign wr_ack   = wr_ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with RD_LAT=1 and one with RD_LAT=3 share stimulus.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst_;
  logic [4:0] addr;
  logic       rd, wr;
  logic [7:0] data_in;
  logic [7:0] dout1, dout3;
  logic       oe1, oe3, rdy1, rdy3, ack1, ack3, err1, err3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(1)) u1 (
    .clk(clk), .rst_(rst_), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(dout1), .data_oe(oe1), .ready(rdy1), .wr_ack(ack1), .err(err1));

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(3)) u3 (
    .clk(clk), .rst_(rst_), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(dout3), .data_oe(oe3), .ready(rdy3), .wr_ack(ack3), .err(err3));

  typedef struct {
    logic       rd;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] e_out;
    logic       e_oe;
    logic       e_rdy;
    logic       e_ack;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic w, input logic [4:0] a,
                              input logic [7:0] d, input logic [7:0] eo,
                              input logic eoe, input logic erdy,
                              input logic eack, input logic eerr);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.din = d;
    v.e_out = eo; v.e_oe = eoe; v.e_rdy = erdy; v.e_ack = eack; v.e_err = eerr;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    rd = r; wr = w; addr = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic [7:0] eo, input logic eoe,
                        input logic erdy, input logic eack, input logic eerr);
    check({tag, ".u1.data_out"}, 32'(dout1), 32'(eo));
    check({tag, ".u1.data_oe"},  32'(oe1),   32'(eoe));
    check({tag, ".u1.ready"},    32'(rdy1),  32'(erdy));
    check({tag, ".u1.wr_ack"},   32'(ack1),  32'(eack));
    check({tag, ".u1.err"},      32'(err1),  32'(eerr));
  endtask

  task automatic check3(input string tag, input logic [7:0] eo, input logic erdy);
    check({tag, ".u3.data_out"}, 32'(dout3), 32'(eo));
    check({tag, ".u3.data_oe"},  32'(oe3),   32'(erdy));
    check({tag, ".u3.ready"},    32'(rdy3),  32'(erdy));
  endtask

  initial begin
    // rd wr addr din | data_out oe ready wr_ack err   (u1, RD_LAT=1)
    add(0,1, 5'd3,  8'hA5, 8'h00,0,0,1,0);
    add(0,1, 5'd31, 8'h5C, 8'h00,0,0,1,0);
    add(0,1, 5'd2,  8'h22, 8'h00,0,0,1,0);
    add(0,1, 5'd4,  8'h44, 8'h00,0,0,1,0);
    add(0,1, 5'd5,  8'h55, 8'h00,0,0,1,0);
    add(0,1, 5'd15, 8'hF0, 8'h00,0,0,1,0);
    add(0,0, 5'd0,  8'h00, 8'h00,0,0,0,0);
    // read addr 3 held, then released
    add(1,0, 5'd3,  8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd3,  8'h00, 8'hA5,1,1,0,0);
    add(1,0, 5'd3,  8'h00, 8'hA5,1,1,0,0);
    add(0,0, 5'd3,  8'h00, 8'h00,0,0,0,0);
    // write then read back
    add(0,1, 5'd7,  8'h3C, 8'h00,0,0,1,0);
    add(1,0, 5'd7,  8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd7,  8'h00, 8'h3C,1,1,0,0);
    add(0,0, 5'd7,  8'h00, 8'h00,0,0,0,0);
    // address change while driving relaunches
    add(1,0, 5'd2,  8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd2,  8'h00, 8'h22,1,1,0,0);
    add(1,0, 5'd4,  8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd4,  8'h00, 8'h44,1,1,0,0);
    // rd+wr together: err pulse, no write
    add(1,1, 5'd5,  8'hFF, 8'h00,0,0,0,1);
    add(0,0, 5'd5,  8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd5,  8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd5,  8'h00, 8'h55,1,1,0,0);
    add(0,0, 5'd5,  8'h00, 8'h00,0,0,0,0);
    // one-cycle rd drop restarts with full latency
    add(1,0, 5'd3,  8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd3,  8'h00, 8'hA5,1,1,0,0);
    add(0,0, 5'd3,  8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd3,  8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd3,  8'h00, 8'hA5,1,1,0,0);
    // write in DRIVE returns to idle
    add(0,1, 5'd9,  8'h99, 8'h00,0,0,1,0);
    add(1,0, 5'd9,  8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd9,  8'h00, 8'h99,1,1,0,0);
    add(0,0, 5'd9,  8'h00, 8'h00,0,0,0,0);
    // top address, not aliased by addr 15
    add(1,0, 5'd31, 8'h00, 8'h00,0,0,0,0);
    add(1,0, 5'd31, 8'h00, 8'h5C,1,1,0,0);
    add(0,0, 5'd31, 8'h00, 8'h00,0,0,0,0);

    rd = 0; wr = 0; addr = '0; data_in = '0;
    rst_ = 1'b0;
    #2;
    check1("reset", 8'h00, 0, 0, 0, 0);
    check3("reset", 8'h00, 0);
    @(posedge clk); #1;
    rst_ = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
      check1($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_oe, tbl[i].e_rdy,
             tbl[i].e_ack, tbl[i].e_err);
    end

    // RD_LAT=3: top address, then address switch while driving
    for (int c = 1; c <= 4; c++) begin
      step(1, 0, 5'd31, 8'h00);
      check3($sformatf("lat3_c%0d", c), (c == 4) ? 8'h5C : 8'h00, c == 4);
    end
    for (int c = 1; c <= 4; c++) begin
      step(1, 0, 5'd4, 8'h00);
      check3($sformatf("lat3_sw_c%0d", c), (c == 4) ? 8'h44 : 8'h00, c == 4);
    end
    step(0, 0, 5'd4, 8'h00);
    check3("lat3_abort", 8'h00, 0);

    // asynchronous reset mid-DRIVE, then a clean read
    step(1, 0, 5'd3, 8'h00);
    step(1, 0, 5'd3, 8'h00);
    check1("pre_rst", 8'hA5, 1, 1, 0, 0);
    #2;
    rst_ = 1'b0;
    #1;
    check1("async_rst", 8'h00, 0, 0, 0, 0);
    check3("async_rst", 8'h00, 0);
    @(posedge clk); #3;
    rst_ = 1'b1;
    step(1, 0, 5'd3, 8'h00);
    check1("post_rst1", 8'h00, 0, 0, 0, 0);
    step(1, 0, 5'd3, 8'h00);
    check1("post_rst2", 8'hA5, 1, 1, 0, 0);
    step(0, 0, 5'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
